// File: rtl/fetch_run_ctrl.sv
// Run/halt/debug sequencer for the fetch stage: host halt/resume/step,
// debug PC load and NUM_BP hardware PC breakpoints.
module fetch_run_ctrl #(
  parameter int NUM_BP    = 2,
  parameter int RESET_RUN = 0,
  localparam int BPW      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           halt_req_i,
  input  logic           resume_req_i,
  input  logic           step_req_i,
  input  logic           pc_wr_req_i,
  input  logic [31:0]    pc_wr_data_i,
  input  logic           bp_wr_i,
  input  logic [BPW-1:0] bp_idx_i,
  input  logic [31:0]    bp_addr_i,
  input  logic           bp_en_i,
  input  logic [31:0]    pc_i,
  input  logic           pipe_busy_i,
  output logic           run_o,
  output logic           stall_o,
  output logic           pc_wr_debug_o,
  output logic [31:0]    pc_debug_o,
  output logic           halted_o,
  output logic [1:0]     halt_cause_o,
  output logic           cmd_ack_o
);

  typedef enum logic [2:0] {S_RUN, S_DRAIN, S_HALTED, S_STEP, S_PCWR} state_t;
  localparam state_t RESET_STATE = (RESET_RUN != 0) ? S_RUN : S_HALTED;

  state_t            state;
  logic [29:0]       bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_en;
  logic              skip;
  logic [31:0]       skip_pc;
  logic              ack_pend;
  logic              bp_raw;
  logic              bp_hit;
  logic              ack_req;

  // skip suppresses the breakpoint we are resuming or stepping off
  always_comb begin
    bp_raw = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++)
      if (bp_en[i] && (pc_i[31:2] == bp_addr[i])) bp_raw = 1'b1;
    bp_hit = bp_raw && !(skip && (pc_i == skip_pc));
  end

  always_comb begin
    ack_req = 1'b0;
    case (state)
      S_DRAIN:  ack_req = !pipe_busy_i;
      S_PCWR:   ack_req = 1'b1;
      S_HALTED: ack_req = resume_req_i && !step_req_i && !pc_wr_req_i;
      default:  ack_req = 1'b0;
    endcase
  end

  assign run_o         = ((state == S_RUN) && !bp_hit) || (state == S_STEP) || (state == S_PCWR);
  assign stall_o       = (state == S_PCWR);
  assign pc_wr_debug_o = (state == S_PCWR);
  assign halted_o      = (state == S_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RESET_STATE;
      halt_cause_o <= 2'd3;
      pc_debug_o   <= '0;
      skip         <= 1'b0;
      skip_pc      <= '0;
      cmd_ack_o    <= 1'b0;
      ack_pend     <= 1'b0;
      bp_en        <= '0;
      for (int unsigned i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
    end else begin
      // an ack landing right after another is deferred one cycle, never dropped
      cmd_ack_o <= (ack_req || ack_pend) && !cmd_ack_o;
      ack_pend  <= (ack_req || ack_pend) && cmd_ack_o;

      if (skip && (pc_i != skip_pc)) skip <= 1'b0;

      for (int unsigned i = 0; i < NUM_BP; i++) begin
        if (bp_wr_i && (bp_idx_i == BPW'(i))) begin
          bp_addr[i] <= bp_addr_i[31:2];
          bp_en[i]   <= bp_en_i;
        end
      end

      case (state)
        S_RUN: begin
          if (bp_hit) begin
            state        <= S_DRAIN;
            halt_cause_o <= 2'd2;
          end else if (halt_req_i) begin
            state        <= S_DRAIN;
            halt_cause_o <= 2'd0;
          end
        end
        S_DRAIN: begin
          if (!pipe_busy_i) state <= S_HALTED;
        end
        S_HALTED: begin
          if (pc_wr_req_i) begin
            state      <= S_PCWR;
            pc_debug_o <= pc_wr_data_i;
          end else if (step_req_i) begin
            state   <= S_STEP;
            skip    <= 1'b1;
            skip_pc <= pc_i;
          end else if (resume_req_i) begin
            state   <= S_RUN;
            skip    <= 1'b1;
            skip_pc <= pc_i;
          end
        end
        S_STEP: begin
          state        <= S_DRAIN;
          halt_cause_o <= 2'd1;
        end
        S_PCWR: begin
          state <= S_HALTED;
        end
        default: begin
          state <= RESET_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_run_ctrl.sv
// Bench for fetch_run_ctrl: a fetch PC model plus an ack scoreboard.
module tb_fetch_run_ctrl;

  typedef struct packed {
    logic        halted;
    logic [1:0]  cause;
    logic        run;
    logic [31:0] pc;
  } ack_t;

  logic        clk;
  logic        reset;
  logic        halt_req_i, resume_req_i, step_req_i, pc_wr_req_i;
  logic [31:0] pc_wr_data_i;
  logic        bp_wr_i;
  logic [0:0]  bp_idx_i;
  logic [31:0] bp_addr_i;
  logic        bp_en_i;
  logic [31:0] pc_i;
  logic        pipe_busy_i;
  logic        run_o, stall_o, pc_wr_debug_o, halted_o, cmd_ack_o;
  logic [31:0] pc_debug_o;
  logic [1:0]  halt_cause_o;

  logic [31:0] tb_pc;
  logic [31:0] pc_init;
  ack_t        exp_q[$];
  ack_t        obs_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ack_twice = 0;
  int          both_hi = 0;
  logic        ack_prev = 1'b0;

  fetch_run_ctrl #(.NUM_BP(2), .RESET_RUN(0)) dut (
    .clk(clk), .reset(reset),
    .halt_req_i(halt_req_i), .resume_req_i(resume_req_i), .step_req_i(step_req_i),
    .pc_wr_req_i(pc_wr_req_i), .pc_wr_data_i(pc_wr_data_i),
    .bp_wr_i(bp_wr_i), .bp_idx_i(bp_idx_i), .bp_addr_i(bp_addr_i), .bp_en_i(bp_en_i),
    .pc_i(pc_i), .pipe_busy_i(pipe_busy_i),
    .run_o(run_o), .stall_o(stall_o), .pc_wr_debug_o(pc_wr_debug_o), .pc_debug_o(pc_debug_o),
    .halted_o(halted_o), .halt_cause_o(halt_cause_o), .cmd_ack_o(cmd_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fetch stage: advances 4 per run cycle, loads the debug PC on a write strobe
  always @(posedge clk or posedge reset)
    if (reset)              tb_pc <= pc_init;
    else if (pc_wr_debug_o) tb_pc <= pc_debug_o;
    else if (run_o)         tb_pc <= tb_pc + 32'd4;
  assign pc_i = tb_pc;

  always @(negedge clk) begin
    if (cmd_ack_o && !reset) obs_q.push_back(ack_t'{halted_o, halt_cause_o, run_o, tb_pc});
    if (cmd_ack_o && ack_prev) ack_twice++;
    if (halted_o && run_o) both_hi++;
    ack_prev = cmd_ack_o;
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    ack_t e, o;
    pc_init = 32'h0;
    do_reset();
    n_cmp++;
    if (halted_o !== 1'b1 || halt_cause_o !== 2'd3 || run_o !== 1'b0)
      begin n_err++; $display("FAIL reset_state: halted=%b cause=%0d run=%b, want 1 3 0", halted_o, halt_cause_o, run_o); end
    n_cmp++;
    if (stall_o !== 1'b0 || pc_wr_debug_o !== 1'b0 || cmd_ack_o !== 1'b0 || pc_debug_o !== 32'h0)
      begin n_err++; $display("FAIL reset_outs: stall=%b pcwr=%b ack=%b pcdbg=%h, want all 0", stall_o, pc_wr_debug_o, cmd_ack_o, pc_debug_o); end
    resume_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b0, 2'd3, 1'b1, 32'h0});
    @(negedge clk);
    resume_req_i = 1'b0;
    n_cmp++;
    if (run_o !== 1'b1 || cmd_ack_o !== 1'b1 || halted_o !== 1'b0)
      begin n_err++; $display("FAIL resume_first: run=%b ack=%b halted=%b, want 1 1 0", run_o, cmd_ack_o, halted_o); end
    @(negedge clk);
    n_cmp++;
    if (cmd_ack_o !== 1'b0 || run_o !== 1'b1)
      begin n_err++; $display("FAIL resume_second: ack=%b run=%b, want 0 1", cmd_ack_o, run_o); end
    halt_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b1, 2'd0, 1'b0, tb_pc + 32'd4});
    @(negedge clk);
    halt_req_i = 1'b0;
    wait_halted(10, ok);
    n_cmp++;
    if (!ok || halt_cause_o !== 2'd0 || tb_pc !== 32'h8)
      begin n_err++; $display("FAIL host_halt: ok=%b cause=%0d pc=%h, want 1 0 00000008", ok, halt_cause_o, tb_pc); end
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sb_count_reset: got %0d acks, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_reset: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_breakpoint();
    bit ok, found;
    int bad;
    ack_t e, o;
    pc_init = 32'h0;
    do_reset();
    bp_wr_i = 1'b1; bp_idx_i = 1'b0; bp_addr_i = 32'h40; bp_en_i = 1'b1;
    @(negedge clk);
    bp_idx_i = 1'b1; bp_addr_i = 32'h20; bp_en_i = 1'b1;
    @(negedge clk);
    bp_en_i = 1'b0;
    @(negedge clk);
    bp_wr_i = 1'b0;
    @(negedge clk);
    resume_req_i = 1'b1; pipe_busy_i = 1'b1;
    exp_q.push_back(ack_t'{1'b0, 2'd3, 1'b1, 32'h0});
    found = 1'b0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      resume_req_i = 1'b0;
      if (tb_pc == 32'h40) begin found = 1'b1; break; end
      if (run_o !== 1'b1) bad++;
    end
    n_cmp++;
    if (!found || bad != 0)
      begin n_err++; $display("FAIL bp_run_to: found=%b early_stops=%0d, want 1 0", found, bad); end
    n_cmp++;
    if (run_o !== 1'b0 || halted_o !== 1'b0)
      begin n_err++; $display("FAIL bp_hit_run: run=%b halted=%b at pc 40, want 0 0", run_o, halted_o); end
    exp_q.push_back(ack_t'{1'b1, 2'd2, 1'b0, 32'h40});
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (halted_o || run_o || tb_pc != 32'h40) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL bp_drain: %0d bad cycles, want 0", bad); end
    pipe_busy_i = 1'b0;
    wait_halted(5, ok);
    n_cmp++;
    if (!ok || halt_cause_o !== 2'd2 || tb_pc !== 32'h40)
      begin n_err++; $display("FAIL bp_halted: ok=%b cause=%0d pc=%h, want 1 2 00000040", ok, halt_cause_o, tb_pc); end
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sb_count_bp: got %0d acks, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_bp: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_step();
    bit ok;
    int runs;
    ack_t e, o;
    step_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b1, 2'd1, 1'b0, 32'h44});
    @(negedge clk);
    step_req_i = 1'b0;
    n_cmp++;
    if (run_o !== 1'b1 || tb_pc !== 32'h40 || halted_o !== 1'b0)
      begin n_err++; $display("FAIL step_cycle: run=%b pc=%h halted=%b, want 1 00000040 0", run_o, tb_pc, halted_o); end
    runs = 1;
    repeat (5) begin
      @(negedge clk);
      if (run_o) runs++;
    end
    n_cmp++;
    if (runs != 1 || halted_o !== 1'b1 || halt_cause_o !== 2'd1 || tb_pc !== 32'h44)
      begin n_err++; $display("FAIL step_done: runs=%0d halted=%b cause=%0d pc=%h, want 1 1 1 00000044", runs, halted_o, halt_cause_o, tb_pc); end
    pc_wr_req_i = 1'b1; pc_wr_data_i = 32'h40;
    exp_q.push_back(ack_t'{1'b1, 2'd1, 1'b0, 32'h40});
    @(negedge clk);
    pc_wr_req_i = 1'b0;
    repeat (2) @(negedge clk);
    resume_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b0, 2'd1, 1'b1, 32'h40});
    @(negedge clk);
    resume_req_i = 1'b0;
    n_cmp++;
    if (run_o !== 1'b1 || tb_pc !== 32'h40)
      begin n_err++; $display("FAIL resume_off_bp: run=%b pc=%h, want 1 00000040", run_o, tb_pc); end
    @(negedge clk);
    n_cmp++;
    if (run_o !== 1'b1 || tb_pc !== 32'h44 || halted_o !== 1'b0)
      begin n_err++; $display("FAIL no_rehit: run=%b pc=%h halted=%b, want 1 00000044 0", run_o, tb_pc, halted_o); end
    halt_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b1, 2'd0, 1'b0, 32'h48});
    @(negedge clk);
    halt_req_i = 1'b0;
    wait_halted(5, ok);
    n_cmp++;
    if (!ok || halt_cause_o !== 2'd0) begin n_err++; $display("FAIL step_rehalt: ok=%b cause=%0d, want 1 0", ok, halt_cause_o); end
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sb_count_step: got %0d acks, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_step: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_pcwr();
    ack_t e, o;
    halt_req_i = 1'b1;
    @(negedge clk);
    halt_req_i = 1'b0;
    n_cmp++;
    if (halted_o !== 1'b1 || cmd_ack_o !== 1'b0 || run_o !== 1'b0)
      begin n_err++; $display("FAIL halt_in_halted: halted=%b ack=%b run=%b, want 1 0 0", halted_o, cmd_ack_o, run_o); end
    pc_wr_req_i = 1'b1; pc_wr_data_i = 32'h100; step_req_i = 1'b1; resume_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b1, 2'd0, 1'b0, 32'h100});
    @(negedge clk);
    pc_wr_req_i = 1'b0; step_req_i = 1'b0; resume_req_i = 1'b0;
    n_cmp++;
    if (run_o !== 1'b1 || stall_o !== 1'b1 || pc_wr_debug_o !== 1'b1 || pc_debug_o !== 32'h100 || halted_o !== 1'b0)
      begin n_err++; $display("FAIL pcwr_cycle: run=%b stall=%b pcwr=%b pcdbg=%h halted=%b, want 1 1 1 00000100 0",
                              run_o, stall_o, pc_wr_debug_o, pc_debug_o, halted_o); end
    @(negedge clk);
    n_cmp++;
    if (halted_o !== 1'b1 || stall_o !== 1'b0 || pc_wr_debug_o !== 1'b0 || halt_cause_o !== 2'd0 || tb_pc !== 32'h100 || cmd_ack_o !== 1'b1)
      begin n_err++; $display("FAIL pcwr_done: halted=%b stall=%b pcwr=%b cause=%0d pc=%h ack=%b, want 1 0 0 0 00000100 1",
                              halted_o, stall_o, pc_wr_debug_o, halt_cause_o, tb_pc, cmd_ack_o); end
    @(negedge clk);
    n_cmp++;
    if (halted_o !== 1'b1 || cmd_ack_o !== 1'b0 || run_o !== 1'b0)
      begin n_err++; $display("FAIL pcwr_after: halted=%b ack=%b run=%b, want 1 0 0", halted_o, cmd_ack_o, run_o); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sb_count_pcwr: got %0d acks, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_pcwr: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_halt_vs_bp();
    bit ok, found;
    int bad;
    ack_t e, o;
    bp_wr_i = 1'b1; bp_idx_i = 1'b1; bp_addr_i = 32'h113; bp_en_i = 1'b1;
    @(negedge clk);
    bp_wr_i = 1'b0;
    @(negedge clk);
    resume_req_i = 1'b1; pipe_busy_i = 1'b1;
    exp_q.push_back(ack_t'{1'b0, 2'd0, 1'b1, 32'h100});
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      resume_req_i = 1'b0;
      if (tb_pc == 32'h110) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found || run_o !== 1'b0) begin n_err++; $display("FAIL bp1_hit: found=%b run=%b, want 1 0", found, run_o); end
    halt_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b1, 2'd2, 1'b0, 32'h110});
    @(negedge clk);
    halt_req_i = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (halted_o || tb_pc != 32'h110) bad++;
      if (k < 4) @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL busy_hold: %0d early halted cycles, want 0", bad); end
    pipe_busy_i = 1'b0;
    wait_halted(5, ok);
    n_cmp++;
    if (!ok || halt_cause_o !== 2'd2 || tb_pc !== 32'h110)
      begin n_err++; $display("FAIL bp_wins: ok=%b cause=%0d pc=%h, want 1 2 00000110", ok, halt_cause_o, tb_pc); end
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sb_count_hvb: got %0d acks, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_hvb: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_abort();
    bit ok;
    int bad;
    ack_t e, o;
    resume_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b0, 2'd2, 1'b1, 32'h110});
    @(negedge clk);
    resume_req_i = 1'b0;
    @(negedge clk);
    halt_req_i = 1'b1; pipe_busy_i = 1'b1;
    @(negedge clk);
    halt_req_i = 1'b0;
    n_cmp++;
    if (halted_o !== 1'b0 || run_o !== 1'b0) begin n_err++; $display("FAIL in_drain: halted=%b run=%b, want 0 0", halted_o, run_o); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sb_count_abort: got %0d acks, want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_abort: got %h want %h", o, e); end
    end
    pc_init = 32'h3C;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (halted_o !== 1'b1 || halt_cause_o !== 2'd3 || run_o !== 1'b0 || cmd_ack_o !== 1'b0)
      begin n_err++; $display("FAIL rst_drain: halted=%b cause=%0d run=%b ack=%b, want 1 3 0 0", halted_o, halt_cause_o, run_o, cmd_ack_o); end
    pipe_busy_i = 1'b0;
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || halted_o !== 1'b1 || tb_pc !== 32'h3C)
      begin n_err++; $display("FAIL rst_drain_after: acks=%0d halted=%b pc=%h, want 0 1 0000003c", obs_q.size(), halted_o, tb_pc); end
    resume_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b0, 2'd3, 1'b1, 32'h3C});
    @(negedge clk);
    resume_req_i = 1'b0;
    bad = 0;
    repeat (6) begin
      if (run_o !== 1'b1) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL bps_cleared: %0d stalled cycles past 0x40, want 0", bad); end
    halt_req_i = 1'b1;
    exp_q.push_back(ack_t'{1'b1, 2'd0, 1'b0, tb_pc + 32'd4});
    @(negedge clk);
    halt_req_i = 1'b0;
    wait_halted(5, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sb_count_clr: ok=%b got %0d acks, want %0d", ok, obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sb_clr: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    pc_wr_req_i = 1'b1; pc_wr_data_i = 32'h80;
    @(negedge clk);
    pc_wr_req_i = 1'b0;
    n_cmp++;
    if (stall_o !== 1'b1) begin n_err++; $display("FAIL pcwr_enter: stall=%b, want 1", stall_o); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || pc_wr_debug_o !== 1'b0 || pc_debug_o !== 32'h0 || halted_o !== 1'b1 || cmd_ack_o !== 1'b0)
      begin n_err++; $display("FAIL rst_pcwr: stall=%b pcwr=%b pcdbg=%h halted=%b ack=%b, want 0 0 00000000 1 0",
                              stall_o, pc_wr_debug_o, pc_debug_o, halted_o, cmd_ack_o); end
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0 || halted_o !== 1'b1 || halt_cause_o !== 2'd3 || tb_pc !== 32'h3C)
      begin n_err++; $display("FAIL rst_pcwr_after: acks=%0d halted=%b cause=%0d pc=%h, want 0 1 3 0000003c",
                              obs_q.size(), halted_o, halt_cause_o, tb_pc); end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (ack_twice != 0) begin n_err++; $display("FAIL ack_back_to_back: %0d occurrences, want 0", ack_twice); end
    n_cmp++;
    if (both_hi != 0) begin n_err++; $display("FAIL halted_and_run: %0d cycles, want 0", both_hi); end
  endtask

  initial begin
    reset = 1'b1; pc_init = 32'h0;
    halt_req_i = 1'b0; resume_req_i = 1'b0; step_req_i = 1'b0; pc_wr_req_i = 1'b0;
    pc_wr_data_i = 32'h0; bp_wr_i = 1'b0; bp_idx_i = 1'b0; bp_addr_i = 32'h0; bp_en_i = 1'b0;
    pipe_busy_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_breakpoint();
    test_step();
    test_pcwr();
    test_halt_vs_bp();
    test_reset_abort();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
